scytale_encryption: RTL
=======================

# scytale_encryption

Scytale cipher encoder, the transmit-side counterpart of the scytale decryption stage in the cipher pipeline. It buffers a plaintext byte stream up to a start token. It then writes the buffered text row-major into a key_N × key_M grid and streams it out column-major, one byte per clock. Feeding its output, followed by the token, into the decryption stage with the same keys returns the original plaintext.

## Interface
- D_WIDTH, 8, data byte width
- KEY_WIDTH, 8, width of key_N / key_M
- MAX_NOF_CHARS, 50, plaintext buffer depth in characters
- START_ENCRYPTION_TOKEN, 8'hFA, end-of-plaintext / start-of-encryption marker
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- data_i  input  D_WIDTH  plaintext byte or token
- valid_i  input  1  data_i qualifier
- key_N  input  KEY_WIDTH  grid rows
- key_M  input  KEY_WIDTH  grid columns
- data_o  output  D_WIDTH  ciphertext byte
- valid_o  output  1  data_o qualifier
- busy  output  1  high while encrypting; input is ignored

## Operation
- Reset (rst_n low, any time, asynchronous): data_o=0, valid_o=0, busy=0, buffer cleared to all zero, char count=0, state IDLE.
- FSM states:
  - IDLE: accepts input.
  - EMIT: streams the ciphertext.
  - FLUSH: one-cycle clear.
- IDLE, valid_i=1 and data_i≠token: store data_i at buffer[count], count+1.
  - Count saturates at MAX_NOF_CHARS; further bytes are dropped silently.
- IDLE, valid_i=1 and data_i=token:
  - Latch key_N and key_M.
  - Reset row i and column j to 0.
  - If either latched key is 0: clear the buffer, set count=0, stay IDLE. busy and valid_o stay low.
  - Otherwise set busy=1 and go to EMIT.
- EMIT, each cycle:
  - data_o <= buffer[i*M + j], valid_o <= 1.
  - Index width is 2*KEY_WIDTH.
  - If the index ≥ MAX_NOF_CHARS, data_o <= 0.
  - Counter advance: if i+1==N, then i<=0, j<=j+1; else i<=i+1.
  - After the (N*M)-th output (i==N-1, j==M-1), go to FLUSH.
- FLUSH: busy<=0, valid_o<=0, data_o<=0, buffer cleared, count<=0, then IDLE.
- Exactly N*M bytes are emitted per message. Output position j*N+i carries plaintext[i*M+j].
- Short message (count < N*M): unwritten buffer slots read as 8'h00 (zero padding).
- Long message (count > N*M): characters beyond N*M are not emitted.
- valid_i and data_i are ignored whenever busy=1, including a token.
- key_N and key_M changes while busy have no effect; the latched values are used.

## Timing
- Token accepted at edge T → busy=1 after T.
- First ciphertext byte is valid after edge T+1.
- Last byte is valid after edge T+N*M.
- busy=0, valid_o=0, data_o=0 after edge T+N*M+1.
- busy is high for N*M+1 cycles. valid_o is high for N*M consecutive cycles with no gaps.
- The first new plaintext byte is accepted at the edge after busy falls (edge T+N*M+2 at earliest).
- data_o holds 0 whenever valid_o=0.
- Token with zero key: no output change, one cycle only, next byte accepted at T+1.
- One byte per cycle on input; no back-pressure exists.

## Test plan
- Basic encrypt:
  - Stimulus: N=2, M=3, send 41 42 43 44 45 46 then FA.
  - Required: valid_o for 6 cycles starting at T+1, data_o = 41 44 42 45 43 46.
  - Required: busy high 7 cycles, all outputs 0 afterwards.
- Zero padding: N=2, M=3, send 41 42 43 44 then FA → 41 44 42 00 43 00.
- Round trip: encrypt "HELLOWORLD!!" with N=3, M=4, feed data_o plus FA into the decryption stage → original 12 bytes out.
- Busy protection:
  - Stimulus: during EMIT drive valid_i with 55 and with FA, change key_N to 7; afterwards send 41 42 FA with N=1, M=2.
  - Required: first message unaffected; second message emits exactly 41 42.
- Overflow and zero key:
  - Stimulus: send 52 bytes 01..34 then FA with N=5, M=10.
  - Required: 50 outputs matching the column-major order of bytes 01..32.
  - Stimulus: then send 41 FA with M=0.
  - Required: no valid_o, busy stays 0, buffer cleared.
- Reset mid-stream:
  - Stimulus: pull rst_n low between edges during EMIT.
  - Required: data_o, valid_o, busy drop to 0 immediately, before the next clock edge.
  - Stimulus: after release, send 41 FA with N=1, M=1.
  - Required: single output 41.

Source files
------------

// File: rtl/scytale_encryption.sv
// -----------------------------------------------------------------------------
// scytale_encryption
//
// Scytale cipher encoder. Plaintext bytes are buffered until the start token
// arrives. The buffer is then treated as a key_N x key_M grid filled row-major
// and read back column-major, one ciphertext byte per clock.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst_n    - asynchronous active-low reset
//   data_i   - plaintext byte or start token
//   valid_i  - data_i qualifier (ignored while busy)
//   key_N    - grid rows, latched when the token is accepted
//   key_M    - grid columns, latched when the token is accepted
//   data_o   - ciphertext byte (0 whenever valid_o is low)
//   valid_o  - data_o qualifier
//   busy     - high while a message is being emitted or flushed
// -----------------------------------------------------------------------------
module scytale_encryption #(
  parameter int                     D_WIDTH                = 8,
  parameter int                     KEY_WIDTH              = 8,
  parameter int                     MAX_NOF_CHARS          = 50,
  parameter logic [D_WIDTH-1:0]     START_ENCRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(MAX_NOF_CHARS + 1);
  localparam int ADDR_W = $clog2(MAX_NOF_CHARS);
  localparam int IDX_W  = 2 * KEY_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_s;

  logic [D_WIDTH-1:0]   buf_r [MAX_NOF_CHARS];
  logic [CNT_W-1:0]     count_r;
  logic [KEY_WIDTH-1:0] key_n_r;
  logic [KEY_WIDTH-1:0] key_m_r;
  logic [KEY_WIDTH-1:0] i_r;
  logic [KEY_WIDTH-1:0] j_r;
  logic [D_WIDTH-1:0]   data_o_r;
  logic                 valid_o_r;
  logic                 busy_r;

  logic                 tok_s;
  logic                 byte_s;
  logic                 zero_key_s;
  logic                 last_s;
  logic [KEY_WIDTH-1:0] i_inc_s;
  logic [KEY_WIDTH-1:0] j_inc_s;
  logic [IDX_W-1:0]     idx_s;
  logic [D_WIDTH-1:0]   rd_s;

  assign data_o  = data_o_r;
  assign valid_o = valid_o_r;
  assign busy    = busy_r;

  // Input decode, grid counters and buffer read port
  always_comb begin
    tok_s      = valid_i && (data_i == START_ENCRYPTION_TOKEN);
    byte_s     = valid_i && (data_i != START_ENCRYPTION_TOKEN);
    zero_key_s = (key_N == KEY_WIDTH'(0)) || (key_M == KEY_WIDTH'(0));
    i_inc_s    = i_r + KEY_WIDTH'(1);
    j_inc_s    = j_r + KEY_WIDTH'(1);
    // Last grid cell is (N-1, M-1); compare incremented counters to avoid key-1 underflow.
    last_s     = (i_inc_s == key_n_r) && (j_inc_s == key_m_r);
    // Row-major address of grid cell (i, j), computed at double key width.
    idx_s      = IDX_W'(i_r) * IDX_W'(key_m_r) + IDX_W'(j_r);
    rd_s       = D_WIDTH'(0);
    if (idx_s < IDX_W'(MAX_NOF_CHARS)) begin
      rd_s = buf_r[idx_s[ADDR_W-1:0]];
    end else begin
      rd_s = D_WIDTH'(0);
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (tok_s && !zero_key_s) begin
          state_s = EMIT;
        end else begin
          state_s = IDLE;
        end
      end
      EMIT: begin
        if (last_s) begin
          state_s = FLUSH;
        end else begin
          state_s = EMIT;
        end
      end
      FLUSH:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Plaintext buffer, keys, grid counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_NOF_CHARS; k++) begin
        buf_r[k] <= D_WIDTH'(0);
      end
      count_r   <= CNT_W'(0);
      key_n_r   <= KEY_WIDTH'(0);
      key_m_r   <= KEY_WIDTH'(0);
      i_r       <= KEY_WIDTH'(0);
      j_r       <= KEY_WIDTH'(0);
      data_o_r  <= D_WIDTH'(0);
      valid_o_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (tok_s) begin
            key_n_r <= key_N;
            key_m_r <= key_M;
            i_r     <= KEY_WIDTH'(0);
            j_r     <= KEY_WIDTH'(0);
            if (zero_key_s) begin
              // Degenerate grid: discard the message and keep accepting input.
              for (int k = 0; k < MAX_NOF_CHARS; k++) begin
                buf_r[k] <= D_WIDTH'(0);
              end
              count_r <= CNT_W'(0);
            end else begin
              busy_r <= 1'b1;
            end
          end else if (byte_s) begin
            // Bytes beyond the buffer depth are dropped silently.
            if (count_r < CNT_W'(MAX_NOF_CHARS)) begin
              buf_r[count_r[ADDR_W-1:0]] <= data_i;
              count_r                    <= count_r + CNT_W'(1);
            end
          end
        end
        EMIT: begin
          data_o_r  <= rd_s;
          valid_o_r <= 1'b1;
          // Column-major walk: rows advance fastest.
          if (i_inc_s == key_n_r) begin
            i_r <= KEY_WIDTH'(0);
            j_r <= j_inc_s;
          end else begin
            i_r <= i_inc_s;
          end
        end
        FLUSH: begin
          for (int k = 0; k < MAX_NOF_CHARS; k++) begin
            buf_r[k] <= D_WIDTH'(0);
          end
          count_r   <= CNT_W'(0);
          data_o_r  <= D_WIDTH'(0);
          valid_o_r <= 1'b0;
          busy_r    <= 1'b0;
        end
        default: begin
          data_o_r  <= D_WIDTH'(0);
          valid_o_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule
